burst_accumulator: RTL and testbench

BURST_ACCUMULATOR -- requirements
Module: burst_accumulator

---
 rtl/burst_accumulator.sv | 121 ++++++++++++
 tb/tb_burst_accumulator.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/burst_accumulator.sv
// Burst accumulator: sums a length-tagged burst of operands, tracking sticky unsigned
// carry and signed overflow, and holds the result until the consumer handshakes it.
module burst_accumulator #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned LEN_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [LEN_W-1:0] len,
   input  logic             abort,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_carry,
   output logic             out_ovf,
   output logic [LEN_W-1:0] out_count,
   output logic             busy
);

   typedef enum logic [1:0] {StIdle, StAcc, StDone} state_e;

   state_e           r_state;
   state_e           w_state_next;
   logic [LEN_W-1:0] r_len;
   logic [WIDTH-1:0] r_acc;
   logic             r_carry;
   logic             r_ovf;
   logic [LEN_W-1:0] r_count;
   logic [WIDTH-1:0] r_out_sum;
   logic             r_out_carry;
   logic             r_out_ovf;
   logic [LEN_W-1:0] r_out_count;

   logic             w_start_ok;
   logic             w_beat;
   logic             w_last;
   logic [WIDTH:0]   w_add;
   logic [WIDTH-1:0] w_sum;
   logic             w_carry_step;
   logic             w_ovf_step;
   logic [LEN_W-1:0] w_count_inc;

   assign w_start_ok   = (r_state == StIdle) && start && (len != '0);
   assign w_beat       = (r_state == StAcc) && in_valid && !abort;
   assign w_add        = {1'b0, r_acc} + {1'b0, in_data};
   assign w_sum        = w_add[WIDTH-1:0];
   assign w_carry_step = w_add[WIDTH];
   assign w_ovf_step   = (r_acc[WIDTH-1] == in_data[WIDTH-1]) && (w_sum[WIDTH-1] != r_acc[WIDTH-1]);
   assign w_count_inc  = r_count + LEN_W'(1);
   assign w_last       = w_beat && (w_count_inc == r_len);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Abort outranks both the beat and the result handshake.
   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         StIdle: if (w_start_ok) w_state_next = StAcc;
         StAcc: begin
            if (abort) w_state_next = StIdle;
            else if (w_last) w_state_next = StDone;
         end
         StDone: begin
            if (abort) w_state_next = StIdle;
            else if (out_ready) w_state_next = StIdle;
         end
         default: w_state_next = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_len       <= '0;
         r_acc       <= '0;
         r_carry     <= 1'b0;
         r_ovf       <= 1'b0;
         r_count     <= '0;
         r_out_sum   <= '0;
         r_out_carry <= 1'b0;
         r_out_ovf   <= 1'b0;
         r_out_count <= '0;
      end else if (w_start_ok) begin
         r_len   <= len;
         r_acc   <= '0;
         r_carry <= 1'b0;
         r_ovf   <= 1'b0;
         r_count <= '0;
      end else if (w_beat) begin
         r_acc   <= w_sum;
         r_carry <= r_carry | w_carry_step;
         r_ovf   <= r_ovf | w_ovf_step;
         r_count <= w_count_inc;
         // Result registers load only on the final beat so they hold outside DONE.
         if (w_last) begin
            r_out_sum   <= w_sum;
            r_out_carry <= r_carry | w_carry_step;
            r_out_ovf   <= r_ovf | w_ovf_step;
            r_out_count <= w_count_inc;
         end
      end
   end

   assign in_ready  = (r_state == StAcc);
   assign out_valid = (r_state == StDone);
   assign busy      = (r_state != StIdle);
   assign out_sum   = r_out_sum;
   assign out_carry = r_out_carry;
   assign out_ovf   = r_out_ovf;
   assign out_count = r_out_count;

endmodule

// File: tb/tb_burst_accumulator.sv
// Self-checking bench for burst_accumulator: directed scenarios plus randomized bursts
// compared against an arithmetic reference model.
module tb_burst_accumulator;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [7:0]  len;
   logic        abort;
   logic        in_valid;
   logic [31:0] in_data;
   logic        in_ready;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_sum;
   logic        out_carry;
   logic        out_ovf;
   logic [7:0]  out_count;
   logic        busy;

   int checks   = 0;
   int failures = 0;

   burst_accumulator #(.WIDTH(32), .LEN_W(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .len       (len),
      .abort     (abort),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_carry (out_carry),
      .out_ovf   (out_ovf),
      .out_count (out_count),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [7:0] l);
      start = 1'b1;
      len   = l;
      tick();
      start = 1'b0;
      len   = '0;
   endtask

   task automatic beat(input logic [31:0] d);
      in_valid = 1'b1;
      in_data  = d;
      tick();
      in_valid = 1'b0;
      in_data  = '0;
   endtask

   // Reference: plain integer arithmetic; carry when the unsigned sum exceeds 2^32-1,
   // overflow when the signed sum leaves [-2^31, 2^31-1].
   function automatic void model(input int unsigned q[$], output logic [31:0] s,
                                 output logic c, output logic o);
      longint unsigned ua;
      longint          sx;
      int unsigned     acc;
      int              sa;
      int              sd;
      acc = 0;
      c   = 1'b0;
      o   = 1'b0;
      foreach (q[i]) begin
         ua = longint'(acc) + longint'(q[i]);
         if (ua > 64'h0000_0000_FFFF_FFFF) c = 1'b1;
         sa = acc;
         sd = q[i];
         sx = longint'(sa) + longint'(sd);
         if (sx > 64'sd2147483647 || sx < -64'sd2147483648) o = 1'b1;
         acc = ua[31:0];
      end
      s = acc;
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      checks++;
      if ({in_ready, out_valid, busy} !== 3'b000) begin
         failures++;
         $display("FAIL reset_flags: got ready/valid/busy=%b want 000", {in_ready, out_valid, busy});
      end
      checks++;
      if ({out_sum, out_carry, out_ovf, out_count} !== 42'd0) begin
         failures++;
         $display("FAIL reset_outputs: got sum=%h c=%b o=%b cnt=%0d want all zero",
                  out_sum, out_carry, out_ovf, out_count);
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_basic();
      do_start(8'd3);
      checks++;
      if ({in_ready, busy} !== 2'b11) begin
         failures++;
         $display("FAIL basic_acc_entry: got ready/busy=%b want 11", {in_ready, busy});
      end
      beat(32'd1);
      beat(32'd2);
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("FAIL basic_early_valid: got out_valid=%b want 0", out_valid);
      end
      beat(32'd3);
      checks++;
      if ({out_valid, out_sum, out_carry, out_ovf, out_count} !== {1'b1, 32'd6, 1'b0, 1'b0, 8'd3})
      begin
         failures++;
         $display("FAIL basic_result: got v=%b sum=%0d c=%b o=%b cnt=%0d want v=1 sum=6 c=0 o=0 cnt=3",
                  out_valid, out_sum, out_carry, out_ovf, out_count);
      end
      checks++;
      if (in_ready !== 1'b0) begin
         failures++;
         $display("FAIL basic_ready_in_done: got in_ready=%b want 0", in_ready);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      checks++;
      if ({out_valid, busy, out_sum} !== {1'b0, 1'b0, 32'd6}) begin
         failures++;
         $display("FAIL basic_release: got v=%b busy=%b sum=%0d want v=0 busy=0 sum=6 (held)",
                  out_valid, busy, out_sum);
      end
   endtask

   task automatic test_carry_ovf();
      do_start(8'd2);
      beat(32'hFFFF_FFFF);
      beat(32'h0000_0002);
      checks++;
      if ({out_valid, out_sum, out_carry, out_ovf, out_count} !== {1'b1, 32'h1, 1'b1, 1'b0, 8'd2})
      begin
         failures++;
         $display("FAIL carry_case: got v=%b sum=%h c=%b o=%b cnt=%0d want v=1 sum=00000001 c=1 o=0 cnt=2",
                  out_valid, out_sum, out_carry, out_ovf, out_count);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      do_start(8'd2);
      beat(32'h7FFF_FFFF);
      beat(32'h0000_0001);
      checks++;
      if ({out_valid, out_sum, out_carry, out_ovf} !== {1'b1, 32'h8000_0000, 1'b0, 1'b1}) begin
         failures++;
         $display("FAIL ovf_case: got v=%b sum=%h c=%b o=%b want v=1 sum=80000000 c=0 o=1",
                  out_valid, out_sum, out_carry, out_ovf);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic test_gaps_stall();
      int bad;
      do_start(8'd2);
      beat(32'd10);
      bad = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (in_ready !== 1'b1 || out_valid !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL gap_stall: got %0d bad gap cycles want 0", bad);
      end
      beat(32'd20);
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         start = 1'b1;
         len   = 8'd5;
         tick();
         if ({out_valid, busy, out_sum, out_count} !== {1'b1, 1'b1, 32'd30, 8'd2}) bad++;
      end
      start = 1'b0;
      len   = '0;
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL done_hold: got %0d unstable cycles want 0 (sum=%0d)", bad, out_sum);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      checks++;
      if ({out_valid, busy, in_ready} !== 3'b000) begin
         failures++;
         $display("FAIL gap_idle_after_ready: got v/busy/ready=%b want 000",
                  {out_valid, busy, in_ready});
      end
   endtask

   task automatic test_back_to_back();
      do_start(8'd1);
      beat(32'd7);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      do_start(8'd1);
      checks++;
      if (in_ready !== 1'b1) begin
         failures++;
         $display("FAIL b2b_start: got in_ready=%b want 1", in_ready);
      end
      beat(32'd8);
      checks++;
      if ({out_valid, out_sum, out_count} !== {1'b1, 32'd8, 8'd1}) begin
         failures++;
         $display("FAIL b2b_result: got v=%b sum=%0d cnt=%0d want v=1 sum=8 cnt=1",
                  out_valid, out_sum, out_count);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic test_abort();
      int seen;
      do_start(8'd4);
      beat(32'd9);
      abort    = 1'b1;
      in_valid = 1'b1;
      in_data  = 32'd100;
      tick();
      abort    = 1'b0;
      in_valid = 1'b0;
      checks++;
      if ({in_ready, busy, out_valid} !== 3'b000) begin
         failures++;
         $display("FAIL abort_acc: got ready/busy/valid=%b want 000", {in_ready, busy, out_valid});
      end
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (out_valid === 1'b1) seen++;
      end
      checks++;
      if (seen != 0) begin
         failures++;
         $display("FAIL abort_no_result: got out_valid high %0d cycles want 0", seen);
      end
      do_start(8'd1);
      beat(32'd5);
      checks++;
      if ({out_valid, out_sum, out_count, out_carry, out_ovf} !== {1'b1, 32'd5, 8'd1, 2'b00}) begin
         failures++;
         $display("FAIL abort_no_residue: got v=%b sum=%0d cnt=%0d want v=1 sum=5 cnt=1",
                  out_valid, out_sum, out_count);
      end
      abort     = 1'b1;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      checks++;
      if ({out_valid, busy, out_sum} !== {1'b0, 1'b0, 32'd5}) begin
         failures++;
         $display("FAIL abort_done: got v=%b busy=%b sum=%0d want v=0 busy=0 sum=5",
                  out_valid, busy, out_sum);
      end
      start = 1'b1;
      len   = 8'd1;
      tick();
      start = 1'b0;
      abort = 1'b0;
      checks++;
      if (in_ready !== 1'b1) begin
         failures++;
         $display("FAIL abort_in_idle: got in_ready=%b want 1", in_ready);
      end
      abort = 1'b1;
      tick();
      abort = 1'b0;
   endtask

   task automatic test_reset_mid();
      int seen;
      do_start(8'd3);
      beat(32'd1);
      beat(32'd2);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if ({in_ready, out_valid, busy, out_sum, out_carry, out_ovf, out_count} !== 45'd0) begin
         failures++;
         $display("FAIL reset_mid: got r=%b v=%b b=%b sum=%h c=%b o=%b cnt=%0d want all zero",
                  in_ready, out_valid, busy, out_sum, out_carry, out_ovf, out_count);
      end
      do_start(8'd0);
      seen = 0;
      for (int i = 0; i < 4; i++) begin
         if (busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0) seen++;
         in_valid = 1'b1;
         in_data  = 32'd3;
         tick();
      end
      in_valid = 1'b0;
      checks++;
      if (seen != 0) begin
         failures++;
         $display("FAIL len_zero_ignored: got %0d non-idle cycles want 0", seen);
      end
   endtask

   task automatic test_random();
      int unsigned q[$];
      logic [31:0] es;
      logic        ec;
      logic        eo;
      int          n;
      int          bad;
      for (int b = 0; b < 25; b++) begin
         q.delete();
         n = int'($urandom_range(1, 8));
         for (int i = 0; i < n; i++) begin
            case ($urandom_range(0, 4))
               0: q.push_back(32'h7FFF_FFFF);
               1: q.push_back(32'h8000_0000);
               2: q.push_back(32'hFFFF_FFFF);
               default: q.push_back($urandom);
            endcase
         end
         model(q, es, ec, eo);
         do_start(8'(n));
         bad = 0;
         foreach (q[i]) begin
            for (int g = int'($urandom_range(0, 2)); g > 0; g--) begin
               tick();
               if (in_ready !== 1'b1 || out_valid !== 1'b0) bad++;
            end
            beat(q[i]);
         end
         checks++;
         if (bad != 0) begin
            failures++;
            $display("FAIL rand_gap[%0d]: got %0d bad stall cycles want 0", b, bad);
         end
         for (int w = int'($urandom_range(0, 3)); w >= 0; w--) begin
            checks++;
            if ({out_valid, out_sum, out_carry, out_ovf, out_count} !== {1'b1, es, ec, eo, 8'(n)})
            begin
               failures++;
               $display("FAIL rand_result[%0d]: got v=%b sum=%h c=%b o=%b cnt=%0d want v=1 sum=%h c=%b o=%b cnt=%0d",
                        b, out_valid, out_sum, out_carry, out_ovf, out_count, es, ec, eo, n);
            end
            if (w > 0) tick();
         end
         out_ready = 1'b1;
         tick();
         out_ready = 1'b0;
      end
   endtask

   initial begin
      rst       = 1'b0;
      start     = 1'b0;
      len       = '0;
      abort     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      test_reset();
      test_basic();
      test_carry_ovf();
      test_gaps_stall();
      test_back_to_back();
      test_abort();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
